// File: rtl/pes_seq_gen_ml_fsm.sv
// Serial pattern transmitter: shifts a loaded word out MSB-first for a programmable number of passes.
// Optional SEQ_GEN_GAP_EN inserts GAP_CYCLES idle cycles between passes.
module pes_seq_gen_ml_fsm #(
  parameter  int WIDTH      = 8,
  parameter  int REP_W      = 4,
  parameter  int GAP_CYCLES = 2,
  localparam int LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_repeat,
  input  logic             abort,
  output logic             sequence_out,
  output logic             sequence_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  // A zero gap length is meaningless; such a configuration elaborates this empty marker block.
  if (GAP_CYCLES < 1) begin : g_gap_cycles_out_of_range
  end

  state_t            state_reg;
  logic [WIDTH-1:0]  shreg_reg;
  logic [WIDTH-1:0]  pattern_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  bit_cnt_reg;
  logic [REP_W-1:0]  pass_cnt_reg;
  logic              load_ready_reg;
  logic              out_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              done_reg;

`ifdef SEQ_GEN_GAP_EN
  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_cnt_reg;
`endif

  logic [LEN_W-1:0] eff_len_next;
  logic [LEN_W-1:0] shift_amt_next;
  logic [WIDTH-1:0] aligned_next;

  // The pattern is left-aligned so the bit on the wire is always the register MSB.
  always_comb begin
    eff_len_next = load_len;
    if (load_len == '0 || load_len > WIDTH_L) begin
      eff_len_next = WIDTH_L;
    end
    shift_amt_next = WIDTH_L - eff_len_next;
    aligned_next   = load_data << shift_amt_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      pattern_reg    <= '0;
      len_reg        <= '0;
      bit_cnt_reg    <= '0;
      pass_cnt_reg   <= '0;
      load_ready_reg <= 1'b1;
      out_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (load_valid && load_ready_reg) begin
            state_reg      <= SHIFT;
            pattern_reg    <= aligned_next;
            shreg_reg      <= aligned_next;
            len_reg        <= eff_len_next;
            bit_cnt_reg    <= eff_len_next;
            pass_cnt_reg   <= load_repeat;
            out_reg        <= aligned_next[WIDTH-1];
            valid_reg      <= 1'b1;
            busy_reg       <= 1'b1;
            load_ready_reg <= 1'b0;
          end
        end

        SHIFT: begin
          if (abort) begin
            state_reg      <= IDLE;
            out_reg        <= 1'b0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            load_ready_reg <= 1'b1;
          end else if (bit_cnt_reg != ONE_L) begin
            shreg_reg   <= shreg_reg << 1;
            out_reg     <= shreg_reg[WIDTH-2];
            bit_cnt_reg <= bit_cnt_reg - ONE_L;
          end else if (pass_cnt_reg != '0) begin
            pass_cnt_reg <= pass_cnt_reg - 1'b1;
`ifdef SEQ_GEN_GAP_EN
            state_reg   <= GAP;
            gap_cnt_reg <= GAP_LOAD;
            out_reg     <= 1'b0;
            valid_reg   <= 1'b0;
`else
            shreg_reg   <= pattern_reg;
            out_reg     <= pattern_reg[WIDTH-1];
            bit_cnt_reg <= len_reg;
`endif
          end else begin
            state_reg      <= IDLE;
            out_reg        <= 1'b0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            load_ready_reg <= 1'b1;
          end
        end

`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          if (abort) begin
            state_reg      <= IDLE;
            out_reg        <= 1'b0;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            load_ready_reg <= 1'b1;
          end else if (gap_cnt_reg == '0) begin
            state_reg   <= SHIFT;
            shreg_reg   <= pattern_reg;
            out_reg     <= pattern_reg[WIDTH-1];
            bit_cnt_reg <= len_reg;
            valid_reg   <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
`endif

        // Unused encodings (and GAP when it is not built) fall back to a clean IDLE.
        default: begin
          state_reg      <= IDLE;
          out_reg        <= 1'b0;
          valid_reg      <= 1'b0;
          busy_reg       <= 1'b0;
          done_reg       <= 1'b0;
          load_ready_reg <= 1'b1;
          bit_cnt_reg    <= '0;
          pass_cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign load_ready     = load_ready_reg;
  assign sequence_out   = out_reg;
  assign sequence_valid = valid_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

endmodule
